sync_counter_ctrl: RTL and testbench
====================================

// Module: sync_counter_ctrl
// PURPOSE
//   Run-control sequencer for a WIDTH-bit synchronous up/down counter core.
//   Starts, pauses, resumes and stops counting, and sets the direction and terminal limit.
//   Runs in one-shot or periodic (auto-reload) mode and flags the terminal count.
//   Sits between control logic (start/stop buttons, bus regs) and the counter datapath.
// PARAMETERS
//   WIDTH  2  counter width in bits (>=1)
// PORTS
//   clk       in   1      system clock, rising edge
//   rst       in   1      reset; one clock; reset is asynchronous and active-high
//   start     in   1      begin counting (IDLE/DONE) or resume (PAUSE)
//   stop      in   1      abort to IDLE, clear count
//   pause     in   1      freeze count in RUN
//   en        in   1      count enable (T input); 0 = hold value, FSM state unchanged
//   dir       in   1      0=up, 1=down; sampled on start from IDLE/DONE only
//   periodic  in   1      0=one-shot, 1=auto-reload; sampled with dir
//   limit     in   WIDTH  terminal value; sampled with dir
//   count     out  WIDTH  current counter value
//   tc        out  1      terminal-count pulse, 1 cycle
//   busy      out  1      state is RUN or PAUSE
//   done      out  1      state is DONE (one-shot finished)
// BEHAVIOUR
//   - Reset: state=IDLE, count=0, tc=0, busy=0, done=0, latched dir/periodic/limit=0.
//     Takes effect immediately, including mid-RUN.
//   - All outputs are registered. busy and done decode the state register.
//   - States: IDLE, RUN, PAUSE, DONE.
//   - Priority per edge: stop > pause > start > count.
//   - Initial value is 0 when up, limit when down. Terminal value is limit when up, 0 when down.
//   - IDLE/DONE + start (no stop): latch dir/periodic/limit, count<=initial, ->RUN.
//     The first count step is on the following edge.
//   - RUN, en=1, count!=terminal: count +/-1.
//   - RUN, en=1, count==terminal: tc<=1 for the next cycle only.
//       periodic: count<=initial, stay RUN.
//       one-shot: count holds terminal, ->DONE.
//   - RUN, en=0: count holds, tc=0.
//   - RUN + pause: ->PAUSE, count holds, no tc even if at terminal.
//   - PAUSE + start: ->RUN, no reload. Latched config is kept; the new dir/limit is ignored.
//   - stop in RUN/PAUSE/DONE: ->IDLE, count<=0, tc<=0.
//   - pause in IDLE/PAUSE/DONE: ignored. start in RUN: ignored.
//   - dir/limit/periodic changes while busy: no effect until the next start from IDLE/DONE.
//   - limit=0: initial==terminal.
//       periodic: tc every enabled cycle, count stays 0.
//       one-shot: DONE after one enabled cycle.
//   - Arithmetic is modulo 2^WIDTH. Overflow cannot occur because the terminal check precedes the step.
// STRUCTURE
//   - Package sync_counter_pkg holds:
//       state encodings ST_IDLE=2'b00, ST_RUN=2'b01, ST_PAUSE=2'b10, ST_DONE=2'b11;
//       DIR_UP=1'b0, DIR_DOWN=1'b1.
//   - Sub-module sync_updown_counter_core (clk, rst, load, load_val, en, dir, q) is the counting datapath.
//   - The FSM, config latches, terminal compare and tc register live in the top module.
// TESTING (WIDTH=2, clk period 10)
//   1. rst=1 for 20, release; start, up, periodic, limit=3, en=1
//      -> count 0,1,2,3,0,1 on successive edges.
//      tc=1 in the cycle count shows 0 after 3, and only then.
//   2. Assert rst asynchronously mid-RUN at count=2
//      -> count=0, busy=0, tc=0 before the next edge; IDLE after release.
//   3. start, down, one-shot, limit=2 -> count 2,1,0; then done=1, busy=0, tc one cycle, count holds 0.
//      start again -> count 2, busy=1, done=0.
//   4. Up periodic, en=0 for 40 at count=1 -> count stays 1, no tc.
//      en=1 -> resumes 2,3,0.
//   5. pause at count=1 -> holds 1 and busy=1.
//      start with dir=1, limit=0 -> resumes up 2,3 with old limit.
//      stop -> count=0, IDLE.
//   6. stop+start together in IDLE -> stays IDLE.
//      limit=0 periodic -> tc=1 every enabled cycle.
//      pause+stop in RUN -> IDLE.

Source files
------------

// File: rtl/sync_counter_pkg.sv
// Shared types and encodings for the sync_counter_ctrl run-control sequencer.
package sync_counter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_DONE  = 2'b11
  } state_t;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  // Busy covers both active states so the flag survives a pause.
  function automatic logic state_is_busy(input state_t s);
    return (s == ST_RUN) || (s == ST_PAUSE);
  endfunction

endpackage

// File: rtl/sync_updown_counter_core.sv
// WIDTH-bit loadable up/down counter; load wins over a count step.
module sync_updown_counter_core
  import sync_counter_pkg::*;
#(
  parameter int unsigned WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             dir,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= load_val;
    end else if (en) begin
      if (dir == DIR_UP) q <= q + WIDTH'(1);
      else               q <= q - WIDTH'(1);
    end
  end

endmodule

// File: rtl/sync_counter_ctrl.sv
// Run-control FSM around an up/down counter core: start/pause/resume/stop,
// one-shot or auto-reload operation, and a one-cycle terminal-count pulse.
module sync_counter_ctrl
  import sync_counter_pkg::*;
#(
  parameter int unsigned WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic             en,
  input  logic             dir,
  input  logic             periodic,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             busy,
  output logic             done
);

  state_t           state, state_d;
  logic             dir_q, periodic_q;
  logic [WIDTH-1:0] limit_q;
  logic             cfg_latch;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             step;
  logic             tc_d;
  logic [WIDTH-1:0] init_new, init_lat, term_lat;

  // Initial/terminal values: fresh config at start, latched config while running.
  assign init_new = (dir == DIR_DOWN) ? limit : '0;
  assign init_lat = (dir_q == DIR_DOWN) ? limit_q : '0;
  assign term_lat = (dir_q == DIR_DOWN) ? '0 : limit_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      dir_q      <= 1'b0;
      periodic_q <= 1'b0;
      limit_q    <= '0;
      tc         <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state <= state_d;
      tc    <= tc_d;
      busy  <= state_is_busy(state_d);
      done  <= (state_d == ST_DONE);
      if (cfg_latch) begin
        dir_q      <= dir;
        periodic_q <= periodic;
        limit_q    <= limit;
      end
    end
  end

  // Next state and datapath controls; priority stop > pause > start > count.
  always_comb begin
    state_d   = state;
    cfg_latch = 1'b0;
    load      = 1'b0;
    load_val  = '0;
    step      = 1'b0;
    tc_d      = 1'b0;
    unique case (state)
      ST_IDLE, ST_DONE: begin
        if (stop) begin
          state_d = ST_IDLE;
          load    = 1'b1;
        end else if (start) begin
          state_d   = ST_RUN;
          cfg_latch = 1'b1;
          load      = 1'b1;
          load_val  = init_new;
        end
      end
      ST_RUN: begin
        if (stop) begin
          state_d = ST_IDLE;
          load    = 1'b1;
        end else if (pause) begin
          state_d = ST_PAUSE;
        end else if (en) begin
          if (count == term_lat) begin
            tc_d = 1'b1;
            if (periodic_q) begin
              load     = 1'b1;
              load_val = init_lat;
            end else begin
              state_d = ST_DONE;
            end
          end else begin
            step = 1'b1;
          end
        end
      end
      ST_PAUSE: begin
        if (stop) begin
          state_d = ST_IDLE;
          load    = 1'b1;
        end else if (!pause && start) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  sync_updown_counter_core #(.WIDTH(WIDTH)) u_core (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_val (load_val),
    .en       (step),
    .dir      (dir_q),
    .q        (count)
  );

endmodule

// File: tb/tb_sync_counter_ctrl.sv
// Directed self-checking bench for sync_counter_ctrl with WIDTH=2.
`timescale 1ns/1ps
module tb_sync_counter_ctrl;

  localparam int unsigned WIDTH = 2;

  logic             clk = 1'b0;
  logic             rst, start, stop, pause, en, dir, periodic;
  logic [WIDTH-1:0] limit;
  logic [WIDTH-1:0] count;
  logic             tc, busy, done;

  int checks = 0;
  int errors = 0;

  sync_counter_ctrl #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .pause(pause),
    .en(en), .dir(dir), .periodic(periodic), .limit(limit),
    .count(count), .tc(tc), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Checks count, tc, busy, done in one go.
  task automatic chk_all(input string tag, input int c, input int t, input int b, input int d);
    chk({tag, ".count"}, int'(count), c);
    chk({tag, ".tc"},    int'(tc),    t);
    chk({tag, ".busy"},  int'(busy),  b);
    chk({tag, ".done"},  int'(done),  d);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0; en = 1'b0;
    dir = 1'b0; periodic = 1'b0; limit = '0;
    #20;
    chk_all("reset", 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;

    // 1: up periodic limit=3
    start = 1'b1; dir = 1'b0; periodic = 1'b1; limit = 2'd3; en = 1'b1;
    step(); chk_all("t1.e0", 0, 0, 1, 0);
    start = 1'b0;
    step(); chk_all("t1.e1", 1, 0, 1, 0);
    step(); chk_all("t1.e2", 2, 0, 1, 0);
    step(); chk_all("t1.e3", 3, 0, 1, 0);
    step(); chk_all("t1.e4", 0, 1, 1, 0);
    step(); chk_all("t1.e5", 1, 0, 1, 0);

    // 2: async reset mid-RUN at count=2
    step(); chk("t2.pre", int'(count), 2);
    #2 rst = 1'b1;
    #1 chk_all("t2.async", 0, 0, 0, 0);
    step(); rst = 1'b0;
    step(); chk_all("t2.idle", 0, 0, 0, 0);

    // 3: down one-shot limit=2
    start = 1'b1; dir = 1'b1; periodic = 1'b0; limit = 2'd2;
    step(); chk_all("t3.e0", 2, 0, 1, 0);
    start = 1'b0;
    step(); chk_all("t3.e1", 1, 0, 1, 0);
    step(); chk_all("t3.e2", 0, 0, 1, 0);
    step(); chk_all("t3.done", 0, 1, 0, 1);
    step(); chk_all("t3.hold", 0, 0, 0, 1);
    start = 1'b1;
    step(); chk_all("t3.restart", 2, 0, 1, 0);
    start = 1'b0; stop = 1'b1;
    step(); chk_all("t3.stop", 0, 0, 0, 0);
    stop = 1'b0;

    // 4: en=0 holds the count
    start = 1'b1; dir = 1'b0; periodic = 1'b1; limit = 2'd3;
    step(); chk_all("t4.e0", 0, 0, 1, 0);
    start = 1'b0;
    step(); chk_all("t4.e1", 1, 0, 1, 0);
    en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(); chk_all("t4.hold", 1, 0, 1, 0);
    end
    en = 1'b1;
    step(); chk_all("t4.r2", 2, 0, 1, 0);
    step(); chk_all("t4.r3", 3, 0, 1, 0);
    step(); chk_all("t4.r0", 0, 1, 1, 0);

    // 5: pause, resume ignoring new config, stop
    step(); chk_all("t5.e1", 1, 0, 1, 0);
    pause = 1'b1;
    step(); chk_all("t5.pause", 1, 0, 1, 0);
    pause = 1'b0;
    step(); chk_all("t5.paused", 1, 0, 1, 0);
    start = 1'b1; dir = 1'b1; limit = 2'd0;
    step(); chk_all("t5.resume", 1, 0, 1, 0);
    start = 1'b0;
    step(); chk_all("t5.r2", 2, 0, 1, 0);
    step(); chk_all("t5.r3", 3, 0, 1, 0);
    stop = 1'b1;
    step(); chk_all("t5.stop", 0, 0, 0, 0);
    stop = 1'b0;

    // 6: stop+start in IDLE, limit=0 periodic and one-shot, pause+stop
    stop = 1'b1; start = 1'b1;
    step(); chk_all("t6.stopstart", 0, 0, 0, 0);
    stop = 1'b0; dir = 1'b0; periodic = 1'b1; limit = 2'd0;
    step(); chk_all("t6.e0", 0, 0, 1, 0);
    start = 1'b0;
    step(); chk_all("t6.tc1", 0, 1, 1, 0);
    step(); chk_all("t6.tc2", 0, 1, 1, 0);
    en = 1'b0;
    step(); chk_all("t6.en0", 0, 0, 1, 0);
    en = 1'b1;
    step(); chk_all("t6.tc3", 0, 1, 1, 0);
    pause = 1'b1; stop = 1'b1;
    step(); chk_all("t6.pausestop", 0, 0, 0, 0);
    pause = 1'b0; stop = 1'b0;
    start = 1'b1; periodic = 1'b0;
    step(); chk_all("t6.os.e0", 0, 0, 1, 0);
    start = 1'b0;
    step(); chk_all("t6.os.done", 0, 1, 0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
